// File: rtl/pif_serial_link.sv
// Serial link to a host: 1-cycle-per-bit command/data protocol that bridges
// host read/write requests (single or burst) onto a local word memory port.
module pif_serial_link #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int BURST_WORDS = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ser_in,
    output logic              ser_out,
    input  logic              link_disable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CMD_W  = ADDR_W + 2;
    localparam int MAX_B  = (CMD_W > DATA_W) ? CMD_W : DATA_W;
    localparam int CNT_W  = $clog2(MAX_B + 1);
    localparam int WCNT_W = $clog2(BURST_WORDS);
    localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]  WORD_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  PREFETCH   = CNT_W'(DATA_W - 3);
    localparam logic [WCNT_W-1:0] BURST_LAST = WCNT_W'(BURST_WORDS - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        DECODE,
        ACK,
        RD_DATA,
        WR_WAIT,
        WR_DATA
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, sp;
    logic [CNT_W-1:0]       bit_cnt;
    logic [WCNT_W-1:0]      word_cnt;
    logic [TO_W-1:0]        to_cnt;
    logic [CMD_W-2:0]       cmd_sr;
    logic [CMD_W-1:0]       cmd_next;
    logic [DATA_W-1:0]      data_sr;
    logic                   is_write, is_burst;
    logic                   start_edge, cmd_done, word_done, last_word, ack_timeout;

    // Synchroniser idles high so a released reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            sp     <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ser_in};
            sp     <= s;
        end
    end

    assign s           = sync_q[SYNC_STAGES-1];
    assign start_edge  = ~s & sp;
    assign cmd_next    = {cmd_sr, s};
    assign cmd_done    = (bit_cnt == CMD_LAST);
    assign word_done   = (bit_cnt == WORD_LAST);
    assign last_word   = ~is_burst | (word_cnt == BURST_LAST);
    assign ack_timeout = (state == WR_WAIT) && !start_edge && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_edge && !link_disable) state_next = CMD;
            CMD:     if (cmd_done) state_next = DECODE;
            DECODE:  state_next = ACK;
            ACK:     state_next = is_write ? WR_WAIT : RD_DATA;
            RD_DATA: if (word_done && last_word) state_next = IDLE;
            WR_WAIT: begin
                if (start_edge)       state_next = WR_DATA;
                else if (ack_timeout) state_next = IDLE;
            end
            WR_DATA: if (mem_we && last_word) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Address and read strobe are registered at the end of CMD so both are
    // valid together during DECODE; read data then arrives during ACK.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            to_cnt    <= '0;
            cmd_sr    <= '0;
            data_sr   <= '0;
            is_write  <= 1'b0;
            is_burst  <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    to_cnt   <= '0;
                end
                CMD: begin
                    cmd_sr  <= cmd_next[CMD_W-2:0];
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (cmd_done) begin
                        bit_cnt  <= '0;
                        is_write <= cmd_next[CMD_W-1];
                        is_burst <= cmd_next[CMD_W-2];
                        mem_addr <= cmd_next[ADDR_W-1:0];
                        mem_rd   <= ~cmd_next[CMD_W-1];
                    end
                end
                ACK: begin
                    data_sr  <= mem_rdata;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    to_cnt   <= '0;
                end
                // Next word is fetched two cycles early so it can load gaplessly.
                RD_DATA: begin
                    data_sr <= {data_sr[DATA_W-2:0], 1'b1};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == PREFETCH && !last_word) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                    if (word_done) begin
                        bit_cnt  <= '0;
                        data_sr  <= mem_rdata;
                        word_cnt <= word_cnt + WCNT_W'(1);
                    end
                end
                WR_WAIT: begin
                    to_cnt  <= to_cnt + TO_W'(1);
                    bit_cnt <= '0;
                end
                WR_DATA: begin
                    data_sr <= {data_sr[DATA_W-2:0], s};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (word_done) begin
                        bit_cnt   <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= {data_sr[DATA_W-2:0], s};
                    end
                    if (mem_we && !last_word) begin
                        word_cnt <= word_cnt + WCNT_W'(1);
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A timeout in the same cycle as err_clr leaves the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            err_timeout <= 1'b0;
        else if (ack_timeout) err_timeout <= 1'b1;
        else if (err_clr)     err_timeout <= 1'b0;
    end

    always_comb begin
        ser_out = 1'b1;
        case (state)
            ACK:     ser_out = 1'b0;
            RD_DATA: ser_out = data_sr[DATA_W-1];
            default: ser_out = 1'b1;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_pif_serial_link.sv
// Directed bench for pif_serial_link: acts as host on the serial pins and as
// a registered-read word memory on the local port.
`timescale 1ns/1ps
module tb_pif_serial_link;

    logic        clk = 1'b0;
    logic        reset;
    logic        ser_in;
    logic        ser_out;
    logic        link_disable;
    logic [8:0]  mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        err_timeout;
    logic        err_clr;

    logic [31:0] mem [0:511];
    logic [8:0]  rd_addr_q[$];
    logic [8:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          overlap_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    pif_serial_link dut (
        .clk          (clk),
        .reset        (reset),
        .ser_in       (ser_in),
        .ser_out      (ser_out),
        .link_disable (link_disable),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Memory model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= mem[mem_addr];
            rd_addr_q.push_back(mem_addr);
        end
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (mem_rd && mem_we) overlap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [63:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            ser_in = bits[i];
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_ack(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #1;
            if (ser_out === 1'b0) found = 1'b1;
        end
        check_output(tag, 64'(found), 64'd1);
    endtask

    task automatic do_read(input bit burst, input logic [8:0] addr, input bit dis_mid);
        int          n;
        logic [31:0] word;
        logic [8:0]  a;
        n = burst ? 16 : 1;
        rd_addr_q.delete();
        apply_stimulus(64'({1'b0, 1'b0, burst, addr}), 12);
        ser_in = 1'b1;
        wait_ack("rd_ack");
        if (dis_mid) link_disable = 1'b1;
        for (int w = 0; w < n; w++) begin
            word = '0;
            for (int b = 0; b < 32; b++) begin
                @(posedge clk); #1;
                word = {word[30:0], ser_out};
            end
            a = 9'(addr + 9'(w));
            check_output($sformatf("rd_word%0d", w), 64'(word), 64'(mem[a]));
        end
        @(posedge clk); #1;
        check_output("rd_busy_end", 64'(busy), 64'd0);
        check_output("rd_serout_end", 64'(ser_out), 64'd1);
        link_disable = 1'b0;
        check_output("rd_strobes", 64'(rd_addr_q.size()), 64'(n));
        for (int w = 0; w < n && w < rd_addr_q.size(); w++)
            check_output($sformatf("rd_addr%0d", w), 64'(rd_addr_q[w]), 64'(9'(addr + 9'(w))));
    endtask

    initial begin
        bit          saw_low, saw_busy;
        int          n;
        bit          found;
        logic [31:0] word;

        for (int i = 0; i < 512; i++) mem[i] = 32'h9E3779B9 * 32'(i + 1);
        mem[5] = 32'hDEADBEEF;

        reset = 1'b1; ser_in = 1'b1; link_disable = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ser_out", 64'(ser_out), 64'd1);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_mem_rd", 64'(mem_rd), 64'd0);
        check_output("rst_mem_we", 64'(mem_we), 64'd0);
        check_output("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_output("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_output("rst_err", 64'(err_timeout), 64'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] read single at 0x005");
        do_read(1'b0, 9'h005, 1'b0);

        $display("[TB] read burst at 0x1F8 with link_disable raised mid-transfer");
        do_read(1'b1, 9'h1F8, 1'b1);

        $display("[TB] write burst at 0x010");
        wr_addr_q.delete(); wr_data_q.delete();
        apply_stimulus(64'({1'b0, 2'b11, 9'h010}), 12);
        ser_in = 1'b1;
        wait_ack("wr_ack");
        repeat (5) begin @(posedge clk); #1; end
        apply_stimulus(64'd0, 1);
        for (int w = 0; w < 16; w++) apply_stimulus(64'(w), 32);
        ser_in = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_output("wr_count", 64'(wr_addr_q.size()), 64'd16);
        check_output("wr_busy_end", 64'(busy), 64'd0);
        for (int w = 0; w < wr_addr_q.size() && w < 16; w++) begin
            check_output($sformatf("wr_addr%0d", w), 64'(wr_addr_q[w]), 64'(9'h010 + 9'(w)));
            check_output($sformatf("wr_data%0d", w), 64'(wr_data_q[w]), 64'(w));
        end

        $display("[TB] write single with no host acknowledge");
        wr_addr_q.delete(); wr_data_q.delete();
        apply_stimulus(64'({1'b0, 2'b10, 9'h033}), 12);
        ser_in = 1'b1;
        wait_ack("to_ack");
        n = 0; found = 1'b0;
        while (n < 1200 && !found) begin
            @(posedge clk); #1;
            n++;
            if (err_timeout === 1'b1) found = 1'b1;
        end
        check_output("to_cycles", 64'(n), 64'd1024);
        check_output("to_busy", 64'(busy), 64'd0);
        repeat (5) begin @(posedge clk); #1; end
        check_output("to_sticky", 64'(err_timeout), 64'd1);
        check_output("to_no_we", 64'(wr_addr_q.size()), 64'd0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check_output("to_cleared", 64'(err_timeout), 64'd0);

        $display("[TB] start edge while link_disable is high");
        rd_addr_q.delete();
        link_disable = 1'b1;
        apply_stimulus(64'({1'b0, 2'b00, 9'h005}), 12);
        ser_in = 1'b1;
        saw_low = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ser_out !== 1'b1) saw_low = 1'b1;
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check_output("dis_ser_low", 64'(saw_low), 64'd0);
        check_output("dis_busy", 64'(saw_busy), 64'd0);
        check_output("dis_rd", 64'(rd_addr_q.size()), 64'd0);
        link_disable = 1'b0;
        do_read(1'b0, 9'h005, 1'b0);

        $display("[TB] reset during a read burst");
        apply_stimulus(64'({1'b0, 2'b01, 9'h040}), 12);
        ser_in = 1'b1;
        wait_ack("rst_mid_ack");
        word = '0;
        for (int b = 0; b < 10; b++) begin
            @(posedge clk); #1;
            word = {word[30:0], ser_out};
        end
        check_output("rst_mid_bits", 64'(word), 64'(mem[9'h040][31:22]));
        reset = 1'b1;
        #1;
        check_output("rst_mid_ser_out", 64'(ser_out), 64'd1);
        check_output("rst_mid_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        do_read(1'b0, 9'h005, 1'b0);

        check_output("rd_we_overlap", 64'(overlap_cnt), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
